// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, sent LSB-first
// as start bit, 8 data bits and stop bit, with bit timing from an integer clock divider.
module uart_tx #(
    parameter int FREQ_HZ      = 33330000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = FREQ_HZ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       serial_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_d;
    logic             done_d;
    logic             bit_end;

    assign bit_end  = (cnt_q == LAST_CNT);
    assign tx_busy  = (state_q != IDLE);
    assign tx_ready = (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        serial_d = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is decided from the next state so serial_tx can be a flop.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            serial_tx <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            serial_tx <= serial_d;
            tx_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line/busy/done waveforms are built
// per cycle from frame descriptions and compared against a default and a fast instance.
module tb_uart_tx;

    localparam int C_DEF  = 289;
    localparam int C_FAST = 4;

    logic       clk_tb = 1'b0;
    logic       rst_n;
    logic       tx_valid, tx_valid4;
    logic [7:0] tx_data, tx_data4;
    logic       tx_ready, serial_tx, tx_busy, tx_done;
    logic       tx_ready4, serial_tx4, tx_busy4, tx_done4;

    int n_cmp  = 0;
    int n_fail = 0;

    logic exp_line[$];
    logic exp_busy[$];
    logic exp_done[$];

    always #5 clk_tb = ~clk_tb;

    uart_tx dut (
        .clk       (clk_tb),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .serial_tx (serial_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    uart_tx #(.CLKS_PER_BIT(C_FAST)) dut4 (
        .clk       (clk_tb),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid4),
        .tx_data   (tx_data4),
        .tx_ready  (tx_ready4),
        .serial_tx (serial_tx4),
        .tx_busy   (tx_busy4),
        .tx_done   (tx_done4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A frame is ten bit periods: 0, data LSB-first, 1; each held for c cycles.
    task automatic add_frame(input int c, input logic [7:0] d);
        for (int b = 0; b < 10; b++) begin
            logic v;
            v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            repeat (c) begin
                exp_line.push_back(v);
                exp_busy.push_back(1'b1);
                exp_done.push_back(1'b0);
            end
        end
    endtask

    task automatic add_idle(input int n, input bit done_first);
        for (int i = 0; i < n; i++) begin
            exp_line.push_back(1'b1);
            exp_busy.push_back(1'b0);
            exp_done.push_back(done_first && (i == 0));
        end
    endtask

    task automatic truncate(input int n);
        while (exp_line.size() > n) begin
            void'(exp_line.pop_back());
            void'(exp_busy.pop_back());
            void'(exp_done.pop_back());
        end
    endtask

    task automatic apply_stimulus(input bit use4, input logic [7:0] d, input string tag);
        @(negedge clk_tb);
        check_val({tag, "_ready_before"}, use4 ? tx_ready4 : tx_ready, 32'd1);
        if (use4) begin
            tx_valid4 = 1'b1;
            tx_data4  = d;
        end else begin
            tx_valid = 1'b1;
            tx_data  = d;
        end
        @(negedge clk_tb);
    endtask

    // Cycle k=1 is the first cycle after the handshake edge.
    task automatic check_output(input bit use4, input string tag, input logic [7:0] next_data,
                                input int drop_at, input int noise_at, input int reset_at);
        int n;
        int e_line, e_busy, e_done, e_ready;
        int f_line, f_busy, f_done, f_ready;
        n = exp_line.size();
        e_line = 0; e_busy = 0; e_done = 0; e_ready = 0;
        f_line = -1; f_busy = -1; f_done = -1; f_ready = -1;
        for (int k = 1; k <= n; k++) begin
            logic s, b, dn, r;
            if (k > 1) @(negedge clk_tb);
            s  = use4 ? serial_tx4 : serial_tx;
            b  = use4 ? tx_busy4   : tx_busy;
            dn = use4 ? tx_done4   : tx_done;
            r  = use4 ? tx_ready4  : tx_ready;
            if (s !== exp_line[k-1]) begin e_line++; if (f_line < 0) f_line = k; end
            if (b !== exp_busy[k-1]) begin e_busy++; if (f_busy < 0) f_busy = k; end
            if (dn !== exp_done[k-1]) begin e_done++; if (f_done < 0) f_done = k; end
            if (r !== !exp_busy[k-1]) begin e_ready++; if (f_ready < 0) f_ready = k; end
            if (k == 1) begin
                if (use4) tx_data4 = next_data;
                else tx_data = next_data;
            end
            if (k == drop_at) begin
                if (use4) tx_valid4 = 1'b0;
                else tx_valid = 1'b0;
            end
            if (noise_at > 0 && k == noise_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (noise_at > 0 && k == noise_at + 1) tx_valid = 1'b0;
            if (reset_at > 0 && k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_val({tag, "_serial_in_reset"}, serial_tx, 32'd1);
                check_val({tag, "_busy_in_reset"}, tx_busy, 32'd0);
                check_val({tag, "_done_in_reset"}, tx_done, 32'd0);
            end
            if (reset_at > 0 && k == reset_at + 3) rst_n = 1'b1;
        end
        check_val($sformatf("%s_line_errors(first@%0d)", tag, f_line), e_line, 32'd0);
        check_val($sformatf("%s_busy_errors(first@%0d)", tag, f_busy), e_busy, 32'd0);
        check_val($sformatf("%s_done_errors(first@%0d)", tag, f_done), e_done, 32'd0);
        check_val($sformatf("%s_ready_errors(first@%0d)", tag, f_ready), e_ready, 32'd0);
        exp_line.delete();
        exp_busy.delete();
        exp_done.delete();
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [7:0] d;
        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_valid4 = 1'b0;
        tx_data   = 8'h00;
        tx_data4  = 8'h00;
        repeat (3) @(negedge clk_tb);
        check_val("rst_serial", serial_tx, 32'd1);
        check_val("rst_busy", tx_busy, 32'd0);
        check_val("rst_done", tx_done, 32'd0);
        check_val("rst_serial4", serial_tx4, 32'd1);
        rst_n = 1'b1;
        @(negedge clk_tb);
        check_val("post_rst_ready", tx_ready, 32'd1);
        check_val("post_rst_ready4", tx_ready4, 32'd1);

        $display("[TB] single frame 0x61");
        add_frame(C_DEF, 8'h61);
        add_idle(3, 1'b1);
        apply_stimulus(1'b0, 8'h61, "t1");
        check_output(1'b0, "t1", 8'($urandom), 1, 0, 0);

        $display("[TB] back-to-back 0x88, 0x61 with tx_valid held");
        add_frame(C_DEF, 8'h88);
        add_idle(1, 1'b1);
        add_frame(C_DEF, 8'h61);
        add_idle(3, 1'b1);
        apply_stimulus(1'b0, 8'h88, "t2");
        check_output(1'b0, "t2", 8'h61, 10 * C_DEF + 2, 0, 0);

        $display("[TB] tx_valid pulse while busy is ignored");
        add_frame(C_DEF, 8'h88);
        add_idle(2 * C_DEF, 1'b1);
        apply_stimulus(1'b0, 8'h88, "t3");
        check_output(1'b0, "t3", 8'($urandom), 1, 1000, 0);

        $display("[TB] reset mid-frame, then a clean frame");
        add_frame(C_DEF, 8'h00);
        truncate(1500);
        add_idle(20, 1'b0);
        apply_stimulus(1'b0, 8'h00, "t4");
        check_output(1'b0, "t4", 8'($urandom), 1, 0, 1500);
        d = 8'($urandom);
        add_frame(C_DEF, d);
        add_idle(3, 1'b1);
        apply_stimulus(1'b0, d, "t4b");
        check_output(1'b0, "t4b", 8'($urandom), 1, 0, 0);

        $display("[TB] fast instance: 0xA5 then random bytes");
        add_frame(C_FAST, 8'hA5);
        add_idle(2, 1'b1);
        apply_stimulus(1'b1, 8'hA5, "t6");
        check_output(1'b1, "t6", 8'($urandom), 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            add_frame(C_FAST, d);
            add_idle(1 + int'($urandom_range(0, 3)), 1'b1);
            apply_stimulus(1'b1, d, $sformatf("r%0d", i));
            check_output(1'b1, $sformatf("r%0d", i), 8'($urandom), 1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter, the transmit counterpart of the UART_top receive path.
- Accepts one byte per valid/ready handshake from on-chip logic and serialises it LSB-first on serial_tx.
- Frame: start bit, 8 data bits, 1 stop bit.
- Bit timing is derived from the system clock by an integer divider.
- Used for loopback against the receiver and for debug/console output from the board.

Parameters:
FREQ_HZ, 33330000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate
CLKS_PER_BIT, FREQ_HZ/BAUD_RATE (=289), clock cycles per bit, integer truncation; must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_valid  input  1  tx_data holds a byte to send
tx_data  input  8  byte to transmit, sampled only on handshake
tx_ready  output  1  block can accept a byte (high only in IDLE)
serial_tx  output  1  UART line, idle high
tx_busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (async assert, sync deassert by usage):
  - state=IDLE, serial_tx=1, tx_busy=0, tx_done=0.
  - Bit counter, cycle counter and shift register cleared.
  - tx_ready=1 while rst_n high and in IDLE.
- Handshake:
  - Transfer occurs on a rising edge with tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge; later changes to tx_data are ignored.
  - tx_valid while not ready is ignored; no queueing.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: serial_tx=1. On handshake go to START; clear the cycle counter.
  - START: serial_tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: serial_tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: serial_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Outputs:
  - serial_tx is registered, so no glitches.
  - The first start-bit cycle is the cycle after the handshake edge.
- Timing:
  - Frame length exactly 10*CLKS_PER_BIT cycles (2890 at defaults).
  - tx_done is high for exactly one cycle: the first cycle back in IDLE.
  - tx_ready rises in that same cycle.
  - Back-to-back: if tx_valid is held, the next handshake occurs on that IDLE cycle.
  - Frame-to-frame period is therefore 10*CLKS_PER_BIT+1 cycles, with one extra idle-high cycle between frames.
- Counters:
  - Cycle counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps at bit boundaries.
  - Bit index is 3 bits.
  - No other arithmetic.
- Reset mid-frame: serial_tx returns high immediately (async). The frame is abandoned, and no tx_done is issued.
- tx_busy equals (state != IDLE) and is registered via the state; tx_ready equals !tx_busy.

Test Plan:
1. Reset, then tx_valid=1 with tx_data=0x61 for one cycle.
   - serial_tx low for cycles 1..289 after the handshake.
   - Mid-bit samples at 144+289*k read 0,1,0,0,0,0,1,1,0,1 (start, LSB-first data, stop).
   - tx_done pulses once at cycle 2891.
2. Hold tx_valid=1; send 0x88 then 0x61.
   - Second start bit begins exactly 2891 cycles after the first.
   - tx_ready is high for exactly one cycle between frames.
3. Accept 0x88; pulse tx_valid with tx_data=0xFF at cycle 1000.
   - Transmitted byte remains 0x88, and no second frame occurs.
4. Accept 0x00; assert rst_n=0 at cycle 1500 for 3 cycles.
   - serial_tx=1 within the reset cycle and tx_busy=0.
   - No tx_done pulse.
   - A new handshake after reset produces a full clean frame.
5. Loop serial_tx into UART_top.serial_rx at 33.33 MHz / 115200 and send 0x61.
   - Receiver outputs 0x61 on led, with no framing error.
6. Override parameter CLKS_PER_BIT=4 and send 0xA5.
   - Frame is 40 cycles: bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles long.
